// File: rtl/program_loader.sv
// Assembles MSB-first serial bytes into instruction words and writes them out, one WRITE cycle per word.
// The write strobe follows the 4th accepted byte by one cycle; o_rx_ready is low outside RECV, so bytes offered then stay with the sender.
module program_loader #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           MAX_WORDS  = 64,
    parameter logic [DATA_WIDTH-1:0] HALT_WORD  = 32'hFFFFFFFF
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    output logic                  o_rx_ready,
    output logic [DATA_WIDTH-1:0] o_instruccion,
    output logic [DATA_WIDTH-1:0] o_address,
    output logic                  o_loading,
    output logic                  o_done,
    output logic                  o_overflow,
    output logic [7:0]            o_word_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [7:0]            MAX_CNT   = 8'(MAX_WORDS);
    localparam logic [DATA_WIDTH-1:0] ADDR_STEP = DATA_WIDTH'(4);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] asm_q, asm_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [DATA_WIDTH-1:0] waddr_q, waddr_d;
    logic [7:0]            count_q, count_d;
    logic [DATA_WIDTH-1:0] asm_next;
    logic [7:0]            count_inc;

    assign asm_next  = {asm_q[DATA_WIDTH-9:0], i_rx_data};
    assign count_inc = count_q + 8'd1;

    always_comb begin
        state_d    = state_q;
        asm_d      = asm_q;
        byte_cnt_d = byte_cnt_q;
        addr_d     = addr_q;
        instr_d    = instr_q;
        waddr_d    = waddr_q;
        count_d    = count_q;

        unique case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (i_start) begin
                    state_d    = S_RECV;
                    asm_d      = '0;
                    byte_cnt_d = '0;
                    addr_d     = '0;
                    count_d    = '0;
                end
            end
            S_RECV: begin
                if (i_rx_valid) begin
                    asm_d      = asm_next;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    // Capture the word and its address now so they are stable for the whole WRITE cycle.
                    if (byte_cnt_q == 2'd3) begin
                        instr_d = asm_next;
                        waddr_d = addr_q;
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                count_d = count_inc;
                addr_d  = addr_q + ADDR_STEP;
                // HALT wins over the capacity limit when both hit on the same word.
                if (instr_q == HALT_WORD) begin
                    state_d = S_DONE;
                end else if (count_inc == MAX_CNT) begin
                    state_d = S_ERROR;
                end else begin
                    state_d = S_RECV;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_q    <= S_IDLE;
            asm_q      <= '0;
            byte_cnt_q <= '0;
            addr_q     <= '0;
            instr_q    <= '0;
            waddr_q    <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            asm_q      <= asm_d;
            byte_cnt_q <= byte_cnt_d;
            addr_q     <= addr_d;
            instr_q    <= instr_d;
            waddr_q    <= waddr_d;
            count_q    <= count_d;
        end
    end

    assign o_rx_ready    = (state_q == S_RECV);
    assign o_loading     = (state_q == S_WRITE);
    assign o_done        = (state_q == S_DONE);
    assign o_overflow    = (state_q == S_ERROR);
    assign o_instruccion = instr_q;
    assign o_address     = waddr_q;
    assign o_word_count  = count_q;

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader: a default instance and a MAX_WORDS=4 instance, checked against a byte-stream model.
module tb_program_loader;

    typedef logic [7:0] bq_t[$];
    localparam logic [31:0] HALT = 32'hFFFFFFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    bit          sel;
    logic        start_x;
    logic [7:0]  data_x;
    logic        valid_x;

    logic        rdy_a, load_a, done_a, ovf_a;
    logic [31:0] instr_a, addr_a;
    logic [7:0]  wcnt_a;
    logic        rdy_b, load_b, done_b, ovf_b;
    logic [31:0] instr_b, addr_b;
    logic [7:0]  wcnt_b;

    logic        rdy, loading, done, ovf;
    logic [31:0] instr, addr;
    logic [7:0]  wcnt;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] act_addr[$], act_word[$], exp_addr[$], exp_word[$];
    int          acc_cnt, exp_acc, timing_bad;
    bit          exp_done, exp_ovf;

    always #5 clk = ~clk;

    program_loader dut (
        .i_clock(clk), .i_reset(rst_n),
        .i_start(sel ? 1'b0 : start_x), .i_rx_data(data_x), .i_rx_valid(sel ? 1'b0 : valid_x),
        .o_rx_ready(rdy_a), .o_instruccion(instr_a), .o_address(addr_a), .o_loading(load_a),
        .o_done(done_a), .o_overflow(ovf_a), .o_word_count(wcnt_a)
    );

    program_loader #(.MAX_WORDS(4)) dut4 (
        .i_clock(clk), .i_reset(rst_n),
        .i_start(sel ? start_x : 1'b0), .i_rx_data(data_x), .i_rx_valid(sel ? valid_x : 1'b0),
        .o_rx_ready(rdy_b), .o_instruccion(instr_b), .o_address(addr_b), .o_loading(load_b),
        .o_done(done_b), .o_overflow(ovf_b), .o_word_count(wcnt_b)
    );

    assign rdy     = sel ? rdy_b   : rdy_a;
    assign loading = sel ? load_b  : load_a;
    assign done    = sel ? done_b  : done_a;
    assign ovf     = sel ? ovf_b   : ovf_a;
    assign instr   = sel ? instr_b : instr_a;
    assign addr    = sel ? addr_b  : addr_a;
    assign wcnt    = sel ? wcnt_b  : wcnt_a;

    // Reference: split the byte stream into 4-byte big-endian words; a load ends at HALT or at capacity.
    task automatic model_program(input bq_t bq, input int max_w);
        logic [31:0] w;
        exp_addr.delete(); exp_word.delete();
        exp_done = 1'b0; exp_ovf = 1'b0; exp_acc = bq.size();
        for (int k = 0; 4 * k + 3 < bq.size(); k++) begin
            w = {bq[4*k], bq[4*k+1], bq[4*k+2], bq[4*k+3]};
            exp_addr.push_back(32'(4 * k));
            exp_word.push_back(w);
            if (w == HALT) begin exp_done = 1'b1; exp_acc = 4 * (k + 1); break; end
            if (k + 1 == max_w) begin exp_ovf = 1'b1; exp_acc = 4 * (k + 1); break; end
        end
    endtask

    task automatic make_program(input int nwords, input bit with_halt, output bq_t q);
        logic [31:0] w;
        q.delete();
        for (int k = 0; k < nwords; k++) begin
            w = $urandom;
            if (w == HALT) w = 32'h0;
            for (int b = 3; b >= 0; b--) q.push_back(w[8*b +: 8]);
        end
        if (with_halt) for (int b = 0; b < 4; b++) q.push_back(8'hFF);
    endtask

    // Pulses start, then offers bytes with random valid gaps and random (ignored) start pulses during RECV.
    task automatic drive_program(input bq_t bq, input int gap_pct);
        int idx, quiet, budget;
        bit pend;
        act_addr.delete(); act_word.delete();
        timing_bad = 0; idx = 0; quiet = 0; pend = 1'b0;
        budget = 16 * bq.size() + 40;
        @(negedge clk); valid_x = 1'b0; start_x = 1'b1;
        @(negedge clk); start_x = 1'b0;
        for (int c = 0; c < budget && quiet < 4; c++) begin
            if (loading !== pend) timing_bad++;
            if (loading === 1'b1) begin
                act_addr.push_back(addr);
                act_word.push_back(instr);
                if (rdy !== 1'b0) timing_bad++;
            end
            pend = 1'b0;
            if (idx < bq.size() && int'($urandom_range(99)) >= gap_pct) begin
                valid_x = 1'b1; data_x = bq[idx];
            end else begin
                valid_x = 1'b0; data_x = 8'($urandom);
            end
            if (valid_x && rdy === 1'b1) begin
                idx++;
                pend = (idx % 4 == 0);
            end
            start_x = (rdy === 1'b1) && ($urandom_range(99) < 4);
            if (idx == bq.size()) quiet++;
            @(negedge clk);
        end
        valid_x = 1'b0; start_x = 1'b0;
        acc_cnt = idx;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; sel = 1'b0; start_x = 1'b0; valid_x = 1'b0; data_x = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            n_chk++; if (rdy !== 1'b0)      begin n_fail++; $display("FAIL reset rdy[%0d]: got %b exp 0", s, rdy); end
            n_chk++; if (loading !== 1'b0)  begin n_fail++; $display("FAIL reset loading[%0d]: got %b exp 0", s, loading); end
            n_chk++; if (done !== 1'b0)     begin n_fail++; $display("FAIL reset done[%0d]: got %b exp 0", s, done); end
            n_chk++; if (ovf !== 1'b0)      begin n_fail++; $display("FAIL reset ovf[%0d]: got %b exp 0", s, ovf); end
            n_chk++; if (instr !== 32'h0)   begin n_fail++; $display("FAIL reset instr[%0d]: got %h exp 0", s, instr); end
            n_chk++; if (addr !== 32'h0)    begin n_fail++; $display("FAIL reset addr[%0d]: got %h exp 0", s, addr); end
            n_chk++; if (wcnt !== 8'h0)     begin n_fail++; $display("FAIL reset wcnt[%0d]: got %0d exp 0", s, wcnt); end
        end
        sel = 1'b0;
    endtask

    task automatic check_run(input string name);
        n_chk++; if (acc_cnt !== exp_acc) begin n_fail++; $display("FAIL %s accepted: got %0d exp %0d", name, acc_cnt, exp_acc); end
        n_chk++; if (act_word.size() !== exp_word.size()) begin n_fail++; $display("FAIL %s writes: got %0d exp %0d", name, act_word.size(), exp_word.size()); end
        for (int k = 0; k < exp_word.size() && k < act_word.size(); k++) begin
            n_chk++;
            if (act_addr[k] !== exp_addr[k] || act_word[k] !== exp_word[k]) begin
                n_fail++; $display("FAIL %s write%0d: got %h@%h exp %h@%h", name, k, act_word[k], act_addr[k], exp_word[k], exp_addr[k]);
            end
        end
        n_chk++; if (timing_bad !== 0) begin n_fail++; $display("FAIL %s strobe timing: got %0d bad cycles exp 0", name, timing_bad); end
        n_chk++; if (done !== exp_done) begin n_fail++; $display("FAIL %s done: got %b exp %b", name, done, exp_done); end
        n_chk++; if (ovf !== exp_ovf)   begin n_fail++; $display("FAIL %s overflow: got %b exp %b", name, ovf, exp_ovf); end
        n_chk++; if (wcnt !== 8'(exp_word.size())) begin n_fail++; $display("FAIL %s word_count: got %0d exp %0d", name, wcnt, exp_word.size()); end
        n_chk++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL %s rx_ready after load: got %b exp 0", name, rdy); end
        n_chk++; if (instr !== exp_word[exp_word.size()-1]) begin n_fail++; $display("FAIL %s held instr: got %h exp %h", name, instr, exp_word[exp_word.size()-1]); end
    endtask

    task automatic test_basic;
        bq_t q;
        q = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        sel = 1'b0;
        model_program(q, 64);
        drive_program(q, 0);
        check_run("basic");
        n_chk++;
        if (act_word.size() < 2 || act_addr[0] !== 32'h0 || act_word[0] !== 32'h20080005 ||
            act_addr[1] !== 32'h4 || act_word[1] !== 32'hFFFFFFFF) begin
            n_fail++; $display("FAIL basic literal writes: got %0d writes, first %h@%h exp 20080005@00000000", act_word.size(), act_word[0], act_addr[0]);
        end
    endtask

    task automatic test_random_gaps;
        bq_t q;
        sel = 1'b0;
        for (int r = 0; r < 3; r++) begin
            make_program($urandom_range(2, 6), 1'b1, q);
            model_program(q, 64);
            drive_program(q, $urandom_range(20, 60));
            check_run("gaps");
        end
    endtask

    task automatic test_overflow;
        bq_t q;
        sel = 1'b1;
        make_program(5, 1'b0, q);
        model_program(q, 4);
        drive_program(q, 30);
        check_run("overflow");
        make_program(2, 1'b1, q);
        model_program(q, 4);
        drive_program(q, 30);
        check_run("restart_from_error");
    endtask

    task automatic test_halt_at_max;
        bq_t q;
        sel = 1'b1;
        make_program(3, 1'b1, q);
        model_program(q, 4);
        drive_program(q, 25);
        check_run("halt_at_max");
    endtask

    task automatic test_reset_mid_word;
        bq_t q;
        sel = 1'b0;
        @(negedge clk); start_x = 1'b1;
        @(negedge clk); start_x = 1'b0; valid_x = 1'b1; data_x = 8'hAA;
        @(negedge clk); data_x = 8'hBB;
        @(negedge clk); rst_n = 1'b0; data_x = 8'hCC; start_x = 1'b1;
        @(negedge clk); rst_n = 1'b1; valid_x = 1'b0; start_x = 1'b0;
        n_chk++; if (rdy !== 1'b0 || wcnt !== 8'h0 || addr !== 32'h0 || loading !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL midreset outputs: got rdy=%b cnt=%0d addr=%h load=%b done=%b exp all 0", rdy, wcnt, addr, loading, done);
        end
        q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        model_program(q, 64);
        drive_program(q, 20);
        check_run("midreset");
        n_chk++; if (act_word.size() < 1 || act_word[0] !== 32'h11223344 || act_addr[0] !== 32'h0) begin
            n_fail++; $display("FAIL midreset first write: got %h@%h exp 11223344@00000000", act_word[0], act_addr[0]);
        end
    endtask

    task automatic test_back_to_back;
        bq_t q;
        sel = 1'b0;
        for (int r = 0; r < 2; r++) begin
            make_program($urandom_range(1, 4), 1'b1, q);
            model_program(q, 64);
            drive_program(q, 0);
            check_run("back_to_back");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random_gaps();
        test_overflow();
        test_halt_at_max();
        test_reset_mid_word();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 32: instruction and address width.
REQ-002 Parameter MAX_WORDS, default 64: instruction-memory capacity in words; legal range 2..255.
REQ-003 Parameter HALT_WORD, default 32'hFFFFFFFF: end-of-program marker.
REQ-004 i_clock  input  1  single clock; all state changes on its rising edge.
REQ-005 i_reset  input  1  reset, synchronous, active-low (0 = reset).
REQ-006 i_start  input  1  single-cycle pulse that begins a program load.
REQ-007 i_rx_data  input  8  byte from the serial receiver.
REQ-008 i_rx_valid  input  1  i_rx_data holds a valid byte.
REQ-009 o_rx_ready  output  1  loader accepts a byte this cycle.
REQ-010 o_instruccion  output  DATA_WIDTH  assembled instruction word for instruction memory.
REQ-011 o_address  output  DATA_WIDTH  byte address of o_instruccion.
REQ-012 o_loading  output  1  write strobe for instruction memory; pipeline held while a load is in progress.
REQ-013 o_done  output  1  program fully loaded; pipeline may run.
REQ-014 o_overflow  output  1  program exceeded MAX_WORDS with no HALT_WORD.
REQ-015 o_word_count  output  8  number of words written in the current load.

Function
REQ-016 States SHALL be IDLE, RECV, WRITE, DONE and ERROR, one-hot or binary; encoding is free.
REQ-017 IDLE: o_rx_ready=0; i_start=1 -> RECV; the step also clears the address, the byte counter, o_word_count, o_done and o_overflow.
REQ-018 RECV: o_rx_ready=1; a byte is accepted only when i_rx_valid & o_rx_ready are both high in the same cycle.
REQ-019 Byte assembly is MSB-first: word <= {word[23:0], i_rx_data}; a 2-bit byte counter wraps 3 -> 0.
REQ-020 Acceptance of the 4th byte in cycle N -> WRITE in cycle N+1.
REQ-021 WRITE lasts exactly one cycle: o_loading=1, o_instruccion=assembled word, o_address=current address, o_rx_ready=0.
REQ-022 o_loading SHALL be 0 in every state other than WRITE; o_instruccion and o_address are registered and hold their last values outside WRITE.
REQ-023 On leaving WRITE, o_word_count increments by 1 and the address increments by 4.
REQ-024 If the written word equals HALT_WORD -> DONE; the HALT word itself is written to memory.
REQ-025 Else if the new o_word_count equals MAX_WORDS -> ERROR.
REQ-026 Else -> RECV.
REQ-027 DONE: o_done=1, o_rx_ready=0; i_start=1 -> RECV with the same clears as REQ-017.
REQ-028 ERROR: o_overflow=1, o_rx_ready=0; i_start=1 -> RECV with the same clears; incoming bytes are ignored.
REQ-029 i_start SHALL be ignored in RECV and WRITE; a partial word is never discarded by i_start.
REQ-030 Bytes offered while o_rx_ready=0 SHALL NOT be consumed, and no byte data is lost across WRITE.
REQ-031 If HALT_WORD arrives as word number MAX_WORDS, REQ-024 takes priority over REQ-025: o_done=1 and o_overflow=0.

Reset
REQ-032 When i_reset=0 at a clock edge, the next state SHALL be IDLE with all outputs 0, the assembly register 0, the byte counter 0 and the address 0.
REQ-033 Reset SHALL take priority over i_start and i_rx_valid.
REQ-034 Reset mid-word or mid-WRITE SHALL abort the load; a later load starts again at address 0.

Verification
REQ-035 Bench scenarios:
- Reset held 2 cycles, then released -> all outputs 0, state IDLE, o_rx_ready=0.
- i_start; bytes 20,08,00,05 then FF,FF,FF,FF -> o_loading pulses twice: (0x00000000, 0x20080005), then (0x00000004, 0xFFFFFFFF); o_done=1, o_word_count=2.
- i_rx_valid toggled randomly with gaps during RECV -> the same words are produced and o_loading is high for one cycle per word, exactly one cycle after the 4th byte is accepted.
- MAX_WORDS=4; four non-HALT words -> o_overflow=1 after the 4th write, o_done=0, o_rx_ready=0; a 5th word's bytes are not accepted.
- MAX_WORDS=4; HALT as the 4th word -> o_done=1, o_overflow=0.
- Reset asserted after 2 bytes of word 1, then i_start followed by a full program -> the first write is at address 0x00000000 and contains only the post-reset bytes.
